// File: rtl/sata_pkg.sv
// Shared SATA disk-block constants and the read-side unpacker state type.
package sata_pkg;

    localparam int SATA_SAMPLE_WORDS = 565;
    localparam int SATA_BLOCK_WORDS  = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/sata_unpack_skid.sv
// Two-entry valid/ready buffer carrying {data, sof, eof}; the head entry
// drives the outputs directly so they stay put while the consumer stalls.
module sata_unpack_skid (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [33:0] i_payload,
    output logic        o_valid,
    output logic [33:0] o_payload,
    input  logic        i_ready,
    output logic [1:0]  o_count
);

    logic [33:0] r_head;
    logic [33:0] r_tail;
    logic [1:0]  r_count;
    logic        w_pop;

    assign w_pop = (r_count != 2'd0) && i_ready;

    // Head/tail storage; the upstream credit check guarantees no push when full.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_valid) begin
                        r_head  <= i_payload;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_valid && w_pop) begin
                        r_head <= i_payload;
                    end else if (i_valid) begin
                        r_tail  <= i_payload;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_valid   = (r_count != 2'd0);
    assign o_payload = r_head;
    assign o_count   = r_count;

endmodule

// File: rtl/sata_read_unpacker.sv
// Strips the zero pad from each SATA read block, tags sample start/end,
// counts delivered samples and flags any non-zero pad word.
module sata_read_unpacker
    import sata_pkg::*;
#(
    parameter int SAMPLE_WORDS = SATA_SAMPLE_WORDS,
    parameter int BLOCK_WORDS  = SATA_BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [31:0] sample_count,
    output logic        pad_error
);

    localparam int POS_W = $clog2(BLOCK_WORDS);
    localparam logic [POS_W-1:0] SAMPLE_LIM = POS_W'(SAMPLE_WORDS);
    localparam logic [POS_W-1:0] LAST_DATA  = POS_W'(SAMPLE_WORDS - 1);
    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(BLOCK_WORDS - 1);

    unpack_state_t    r_state;
    logic [POS_W-1:0] r_pos;
    logic             r_inflight;
    logic             r_tag_data;
    logic             r_tag_sof;
    logic             r_tag_eof;
    logic [31:0]      r_sample_count;
    logic             r_pad_error;

    logic [1:0]       w_skid_count;
    logic             w_skid_valid;
    logic [33:0]      w_skid_payload;
    logic             w_accept;
    logic [2:0]       w_credit_sum;
    logic             w_credit_ok;
    logic             w_rd_en;
    logic             w_push;
    logic             w_pad_bad;

    // A pop is only allowed when the word it returns is guaranteed a skid slot.
    assign w_accept     = w_skid_valid && out_ready;
    assign w_credit_sum = {1'b0, w_skid_count} + {2'b00, r_inflight} - {2'b00, w_accept};
    assign w_credit_ok  = (r_state == PAD) || (w_credit_sum < 3'd2);
    assign w_rd_en      = (r_state != IDLE) && enable && !fifo_empty && w_credit_ok;

    // Returned words are routed by the tag captured when they were popped.
    assign w_push    = r_inflight && r_tag_data && enable;
    assign w_pad_bad = r_inflight && !r_tag_data && enable && (fifo_dout != 32'd0);

    // Block-position FSM; pos counts issued pops so the tag lines up with FIFO latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pos      <= '0;
            r_inflight <= 1'b0;
            r_tag_data <= 1'b0;
            r_tag_sof  <= 1'b0;
            r_tag_eof  <= 1'b0;
        end else if (!enable) begin
            r_state    <= IDLE;
            r_pos      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_tag_data <= (r_pos < SAMPLE_LIM);
            r_tag_sof  <= (r_pos == '0);
            r_tag_eof  <= (r_pos == LAST_DATA);
            case (r_state)
                IDLE: begin
                    r_state <= DATA;
                    r_pos   <= '0;
                end
                default: begin
                    if (w_rd_en) begin
                        if (r_pos == LAST_POS) begin
                            r_pos   <= '0;
                            r_state <= DATA;
                        end else begin
                            r_pos <= r_pos + 1'b1;
                            if (r_pos == LAST_DATA) begin
                                r_state <= PAD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Sample counter and sticky pad checker, both restarted on each enable rise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sample_count <= 32'd0;
            r_pad_error    <= 1'b0;
        end else if ((r_state == IDLE) && enable) begin
            r_sample_count <= 32'd0;
            r_pad_error    <= 1'b0;
        end else begin
            if (w_accept && w_skid_payload[0]) begin
                r_sample_count <= r_sample_count + 32'd1;
            end
            if (w_pad_bad) begin
                r_pad_error <= 1'b1;
            end
        end
    end

    sata_unpack_skid u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (!enable),
        .i_valid   (w_push),
        .i_payload ({fifo_dout, r_tag_sof, r_tag_eof}),
        .o_valid   (w_skid_valid),
        .o_payload (w_skid_payload),
        .i_ready   (out_ready),
        .o_count   (w_skid_count)
    );

    assign fifo_rd_en   = w_rd_en;
    assign out_valid    = w_skid_valid;
    assign out_data     = w_skid_payload[33:2];
    assign out_sof      = w_skid_payload[1];
    assign out_eof      = w_skid_payload[0];
    assign sample_count = r_sample_count;
    assign pad_error    = r_pad_error;

endmodule

// File: tb/tb_sata_read_unpacker.sv
// Bench for sata_read_unpacker: a queue-based FIFO model feeds whole disk
// blocks, and a scoreboard holds the sample words expected downstream.
module tb_sata_read_unpacker;
    import sata_pkg::*;

    localparam int SW = SATA_SAMPLE_WORDS;
    localparam int BW = SATA_BLOCK_WORDS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = 32'd0;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sof;
    logic        out_eof;
    logic [31:0] sample_count;
    logic        pad_error;

    typedef struct {
        int blocks;
        int readyPct;
        int gapPct;
        bit randData;
        int badPos;
        int expOutputs;
        int expCount;
        bit expPadErr;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] fifoQ[$];
    logic [33:0] expQ[$];
    int          readyPct = 100;
    int          gapPct = 0;
    int          popCnt = 0;
    int          underflow = 0;
    int          cycleCnt = 0;
    int          badPopCycle = 0;
    int          badPos = -1;
    int          nOut = 0;
    int          curRun = 0;
    int          maxRun = 0;
    int          runs565 = 0;
    bit          monOn = 1'b0;
    bit          prevStall = 1'b0;
    logic [34:0] prevSnap = '0;
    int          errors = 0;
    int          checks = 0;

    sata_read_unpacker dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .sample_count (sample_count),
        .pad_error    (pad_error)
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model (non-FWFT) plus random out_ready / empty-gap driver.
    initial begin
        logic popNow;
        forever begin
            @(posedge clk);
            popNow = fifo_rd_en;
            #1;
            cycleCnt++;
            if (popNow) begin
                if (fifoQ.size() > 0) begin
                    if (badPos >= 0 && badPopCycle == 0 && (popCnt % BW) == badPos)
                        badPopCycle = cycleCnt;
                    fifo_dout = fifoQ.pop_front();
                    popCnt++;
                end else begin
                    underflow++;
                end
            end
            out_ready  = ($urandom_range(99) < readyPct);
            fifo_empty = ($urandom_range(99) < gapPct) || (fifoQ.size() == 0);
        end
    end

    // Output monitor: scoreboard, stall stability, pad flag timing, run lengths.
    initial begin
        logic [33:0] expWord;
        forever begin
            @(negedge clk);
            if (monOn) begin
                if (prevStall)
                    checkOutput("stall_hold", {out_valid, out_data, out_sof, out_eof}, prevSnap);
                if (out_valid && out_ready) begin
                    nOut++;
                    if (expQ.size() == 0) begin
                        checkOutput("extra_word", {out_data, out_sof, out_eof}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        expWord = expQ.pop_front();
                        checkOutput("word", {out_data, out_sof, out_eof}, expWord);
                    end
                end
                checkOutput("pad_error_timing", pad_error, (badPopCycle > 0) && (cycleCnt > badPopCycle));
                if (out_valid) begin
                    curRun++;
                end else begin
                    if (curRun > maxRun) maxRun = curRun;
                    if (curRun == SW) runs565++;
                    curRun = 0;
                end
                prevStall = out_valid && !out_ready;
                prevSnap  = {out_valid, out_data, out_sof, out_eof};
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    task automatic startRun(input int blocks, input int rPct, input int gPct, input bit randData, input int bad);
        logic [31:0] w;
        @(posedge clk); #2;
        monOn  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        fifoQ.delete();
        expQ.delete();
        popCnt = 0; underflow = 0; badPopCycle = 0; badPos = bad;
        nOut = 0; curRun = 0; maxRun = 0; runs565 = 0;
        readyPct = rPct; gapPct = gPct;
        for (int b = 0; b < blocks; b++) begin
            for (int k = 0; k < BW; k++) begin
                if (k < SW) begin
                    w = randData ? $urandom : 32'(k);
                    expQ.push_back({w, k == 0, k == SW - 1});
                end else begin
                    w = (b == 0 && k == bad) ? 32'hDEADBEEF : 32'd0;
                end
                fifoQ.push_back(w);
            end
        end
        enable = 1'b1;
        @(posedge clk); #2;
        monOn = 1'b1;
    endtask

    task automatic runToCompletion(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #2;
            if (expQ.size() == 0 && fifoQ.size() == 0) done = 1'b1;
        end
        checkOutput("run_timeout", done, 1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input vec_t v);
        startRun(v.blocks, v.readyPct, v.gapPct, v.randData, v.badPos);
        runToCompletion(v.blocks * BW * 8 + 500);
    endtask

    task automatic waitPops(input int target, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(posedge clk); #2;
            if (popCnt >= target) done = 1'b1;
        end
        checkOutput(name, done, 1);
    endtask

    // Main sequence: reset, table-driven block runs, then corner cases.
    initial begin
        bit seen;
        vecs[0] = '{1, 100,  0, 1'b0,   -1,  565, 1, 1'b0};
        vecs[1] = '{3,  50, 25, 1'b1,   -1, 1695, 3, 1'b0};
        vecs[2] = '{1, 100, 10, 1'b1,  700,  565, 1, 1'b1};
        vecs[3] = '{2,  70,  0, 1'b1, 1023, 1130, 2, 1'b1};

        enable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_rd_en", fifo_rd_en, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_sof_eof", {out_sof, out_eof}, 0);
        checkOutput("reset_sample_count", sample_count, 0);
        checkOutput("reset_pad_error", pad_error, 0);
        enable = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d: %0d block(s)", i, vecs[i].blocks);
            applyStimulus(vecs[i]);
            checkOutput("outputs", nOut, vecs[i].expOutputs);
            checkOutput("sample_count", sample_count, vecs[i].expCount);
            checkOutput("pad_error_final", pad_error, vecs[i].expPadErr);
            checkOutput("pops", popCnt, vecs[i].blocks * BW);
            checkOutput("underflow", underflow, 0);
        end

        $display("[TB] back-to-back throughput");
        startRun(2, 100, 0, 1'b1, -1);
        runToCompletion(2 * BW * 4);
        checkOutput("max_valid_run", maxRun, SW);
        checkOutput("full_runs", runs565, 2);
        checkOutput("tp_sample_count", sample_count, 2);

        $display("[TB] enable drop after position 300 of second block");
        startRun(2, 100, 0, 1'b1, -1);
        waitPops(BW + 301, "drop_wait");
        checkOutput("pre_drop_rd_en", fifo_rd_en, 1);
        checkOutput("pre_drop_valid", out_valid, 1);
        checkOutput("pre_drop_count", sample_count, 1);
        monOn  = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("drop_rd_en", fifo_rd_en, 0);
        @(posedge clk); #2;
        checkOutput("drop_out_valid", out_valid, 0);
        startRun(1, 100, 0, 1'b1, -1);
        checkOutput("restart_count", sample_count, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #2;
            end
        end
        checkOutput("restart_valid_seen", seen, 1);
        checkOutput("restart_sof", out_sof, 1);
        runToCompletion(BW * 4);
        checkOutput("restart_final_count", sample_count, 1);

        $display("[TB] reset pulse inside pad region");
        startRun(1, 100, 0, 1'b1, 700);
        waitPops(800, "reset_wait");
        checkOutput("pre_reset_pad_error", pad_error, 1);
        checkOutput("pre_reset_count", sample_count, 1);
        monOn   = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #2;
        checkOutput("mid_reset_valid", out_valid, 0);
        checkOutput("mid_reset_data", out_data, 0);
        checkOutput("mid_reset_sof_eof", {out_sof, out_eof}, 0);
        checkOutput("mid_reset_count", sample_count, 0);
        checkOutput("mid_reset_pad_error", pad_error, 0);
        checkOutput("mid_reset_rd_en", fifo_rd_en, 0);
        checkOutput("mid_reset_pos", 64'(dut.r_pos), 0);
        checkOutput("mid_reset_state", 64'(dut.r_state), 64'(IDLE));
        enable  = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
